// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial LSB-first adder with start/busy/done handshake.
//            Optional ovf output enabled by defining SERIAL_ADDER_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;

    // Full adder from two half-adder cells and an OR.
    logic w_ha0_s, w_ha0_c, w_ha1_s, w_ha1_c, w_s, w_c;
    assign w_ha0_s = r_a_sr[0] ^ r_b_sr[0];
    assign w_ha0_c = r_a_sr[0] & r_b_sr[0];
    assign w_ha1_s = w_ha0_s ^ r_carry;
    assign w_ha1_c = w_ha0_s & r_carry;
    assign w_s     = w_ha1_s;
    assign w_c     = w_ha0_c | w_ha1_c;

    assign w_accept = start && (r_state != S_SHIFT);
    assign w_last   = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_SHIFT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (r_state == S_SHIFT) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                // r_carry here is the carry into the MSB.
                r_ovf  <= r_carry ^ w_c;
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
